ir_nec_rx_ctrl: RTL

Decodes NEC-format infrared frames from the demodulated IR receiver pin and sequences the 32-bit capture input port of the IR data PIO. It presents each validated frame as a stable word plus single-cycle status strobes. The PIO edge-capture logic raises the CPU interrupt from those strobes. The block sits between the board IR pin and the PIO `in_port`, and owns all timing, validation and error handling so software only reads complete frames.

---
 rtl/ir_nec_rx_ctrl_if.sv | 11 +
 rtl/ir_nec_rx_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_nec_rx_ctrl_if.sv
// rtl/ir_nec_rx_ctrl_if.sv - frame word and status strobes from the NEC receiver to the PIO
interface ir_nec_rx_ctrl_if;
  logic [31:0] out_data;
  logic        frame_valid;
  logic        repeat_valid;
  logic        err;
  logic        busy;

  modport master (output out_data, frame_valid, repeat_valid, err, busy);
  modport slave  (input  out_data, frame_valid, repeat_valid, err, busy);
endinterface

// File: rtl/ir_nec_rx_ctrl.sv
// rtl/ir_nec_rx_ctrl.sv - NEC IR frame decoder feeding the IR data PIO capture port
module ir_nec_rx_ctrl #(
  parameter int TICK_CYCLES = 50,
  parameter bit CHECK_INV   = 1'b1,
  parameter int TIMEOUT_US  = 12000,
  parameter int WIN_DIV     = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ir_rx,
  ir_nec_rx_ctrl_if.master  rx_if
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [13:0] DUR_MAX = 14'h3FFF;
  localparam logic [13:0] TMO     = 14'(TIMEOUT_US);

  // Window limits in ticks; WIN_DIV shrinks the whole timing plan uniformly.
  localparam logic [13:0] LM_MIN  = 14'(8000 / WIN_DIV);
  localparam logic [13:0] LM_MAX  = 14'(10000 / WIN_DIV);
  localparam logic [13:0] FS_MIN  = 14'(4000 / WIN_DIV);
  localparam logic [13:0] FS_MAX  = 14'(5000 / WIN_DIV);
  localparam logic [13:0] RS_MIN  = 14'(2000 / WIN_DIV);
  localparam logic [13:0] RS_MAX  = 14'(2500 / WIN_DIV);
  localparam logic [13:0] SH_MIN  = 14'(400 / WIN_DIV);
  localparam logic [13:0] SH_MAX  = 14'(700 / WIN_DIV);
  localparam logic [13:0] B1_MIN  = 14'(1400 / WIN_DIV);
  localparam logic [13:0] B1_MAX  = 14'(1900 / WIN_DIV);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            mark_d_q;
  logic [PRE_W-1:0] pre_q;
  logic [13:0]     dur_q;
  logic [4:0]      bitcnt_q, bitcnt_d;
  logic [31:0]     sh_q, sh_d;
  logic [31:0]     out_q, out_d;
  logic            fv_q, fv_d, rv_q, rv_d, err_q, err_d;

  logic mark, edge_det, mark_start, mark_end, tick, timeout;
  logic short_ok, bit0, bit1;

  function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign mark       = ~sync_q[1];
  assign edge_det   = mark ^ mark_d_q;
  assign mark_start = edge_det & mark;
  assign mark_end   = edge_det & ~mark;
  assign tick       = (pre_q == PRE_LAST);
  assign short_ok   = in_win(dur_q, SH_MIN, SH_MAX);
  assign bit0       = short_ok;
  assign bit1       = in_win(dur_q, B1_MIN, B1_MAX);
  assign timeout    = (state_q != IDLE) && (dur_q >= TMO) && !edge_det;

  // Synchronizer idles high so a released line never looks like a mark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      mark_d_q <= 1'b0;
      pre_q    <= '0;
      dur_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], ir_rx};
      mark_d_q <= mark;
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      if (edge_det)
        dur_q <= '0;
      else if (tick && dur_q != DUR_MAX)
        dur_q <= dur_q + 14'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (mark_start) state_d = LEAD_MARK;
        end
        LEAD_MARK: begin
          if (mark_end) begin
            if (in_win(dur_q, LM_MIN, LM_MAX)) begin
              state_d = LEAD_SPACE;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        LEAD_SPACE: begin
          if (mark_start) begin
            if (in_win(dur_q, FS_MIN, FS_MAX)) begin
              state_d  = BIT_MARK;
              bitcnt_d = '0;
            end else if (in_win(dur_q, RS_MIN, RS_MAX)) begin
              state_d = REP_STOP;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        BIT_MARK: begin
          if (mark_end) begin
            if (short_ok) begin
              state_d = BIT_SPACE;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        BIT_SPACE: begin
          if (mark_start) begin
            if (bit0 || bit1) begin
              // Bytes arrive LSB first, so the first bit ends up at bit 0.
              sh_d     = {bit1, sh_q[31:1]};
              bitcnt_d = bitcnt_q + 5'd1;
              state_d  = (bitcnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        STOP_MARK: begin
          if (mark_end) begin
            state_d = IDLE;
            if (!short_ok) begin
              err_d = 1'b1;
            end else if (CHECK_INV && (sh_q[31:24] != ~sh_q[23:16])) begin
              err_d = 1'b1;
            end else begin
              out_d = sh_q;
              fv_d  = 1'b1;
            end
          end
        end
        REP_STOP: begin
          if (mark_end) begin
            state_d = IDLE;
            if (short_ok) rv_d = 1'b1;
            else          err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign rx_if.out_data     = out_q;
  assign rx_if.frame_valid  = fv_q;
  assign rx_if.repeat_valid = rv_q;
  assign rx_if.err          = err_q;
  assign rx_if.busy         = (state_q != IDLE);

endmodule
